// File: rtl/uart_rx.sv
// Purpose : 16x-oversampling UART receiver (start/data/stop), LSB-first data.
// Latency : line edge reaches the FSM 2 clocks late; done/err pulse the clock after the stop sample tick.
// Backpr. : none -- o_data/o_rx_done are a one-shot result with no ready; the consumer must take it.
//
// Ports
//   i_clock     : system clock, all state on rising edge
//   i_reset     : asynchronous, active-low reset
//   i_tick      : one-clock strobe at 16x baud (may be held high: one count per clock)
//   i_rx        : asynchronous serial line, idles high
//   o_data      : last correctly framed word, updated only together with o_rx_done
//   o_rx_done   : one-clock pulse, frame with a valid (high) stop bit received
//   o_frame_err : one-clock pulse, stop bit sampled low (o_data untouched)
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err
);

  // Bit counter width; a 1-bit frame still needs a 1-bit counter.
  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // The tick counter s stays 4 bits. Stop lengths beyond 16 ticks are
  // handled by an extra high-order counter that counts wraps of s, and the
  // stop end is detected with a compare on the concatenation {stop_hi, s}.
  localparam int HW = ($clog2(STOP_TICKS) > 4) ? ($clog2(STOP_TICKS) - 4) : 1;

  localparam logic [NW-1:0]   N_LAST    = NW'(DATA_BITS - 1);
  localparam logic [HW+3:0]   STOP_LAST = (HW + 4)'(STOP_TICKS - 1);
  localparam logic [3:0]      S_MID     = 4'd7;
  localparam logic [3:0]      S_LAST    = 4'd15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // ---------------------------------------------------------------------
  // Input synchronizer. Both flops reset to the idle (high) line level so a
  // reset never fabricates a falling edge; a line that is genuinely low at
  // reset release shows up as a start bit 2 clocks later and is then
  // vetted by the mid-start-bit check.
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx      <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------
  logic [1:0]           state,    state_nxt;
  logic [3:0]           s,        s_nxt;
  logic [HW-1:0]        stop_hi,  stop_hi_nxt;
  logic [NW-1:0]        n,        n_nxt;
  logic [DATA_BITS-1:0] shreg,    shreg_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 done_nxt;
  logic                 err_nxt;

  // Right shift with the newest sample entering at the MSB, so after the
  // last data bit the first-received bit sits at bit 0.
  logic [DATA_BITS-1:0] shreg_shift;

  if (DATA_BITS > 1) begin : g_shift_wide
    assign shreg_shift = {rx, shreg[DATA_BITS-1:1]};
  end else begin : g_shift_one
    assign shreg_shift = rx;
  end

  always_comb begin
    state_nxt   = state;
    s_nxt       = s;
    stop_hi_nxt = stop_hi;
    n_nxt       = n;
    shreg_nxt   = shreg;
    data_nxt    = o_data;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      // Falling edge is acted on immediately, not on the next tick, so the
      // start-bit phase is measured from the edge itself.
      ST_IDLE: begin
        if (!rx) begin
          state_nxt = ST_START;
          s_nxt     = 4'd0;
        end
      end

      // Count to the middle of the start bit and re-check the line there;
      // a high line means a glitch and we quietly go back to IDLE.
      ST_START: begin
        if (i_tick) begin
          if (s == S_MID) begin
            s_nxt = 4'd0;
            if (!rx) begin
              state_nxt = ST_DATA;
              n_nxt     = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            s_nxt = s + 4'd1;
          end
        end
      end

      // Having aligned to mid-start, every 16th tick is mid-bit.
      ST_DATA: begin
        if (i_tick) begin
          if (s == S_LAST) begin
            s_nxt     = 4'd0;
            shreg_nxt = shreg_shift;
            if (n == N_LAST) begin
              state_nxt   = ST_STOP;
              stop_hi_nxt = '0;
            end else begin
              n_nxt = n + NW'(1);
            end
          end else begin
            s_nxt = s + 4'd1;
          end
        end
      end

      // Stop bit is sampled STOP_TICKS ticks after the last data sample.
      // Returning to IDLE here (mid stop bit for 1 stop bit) leaves half a
      // bit of slack before the next start edge of a back-to-back frame.
      ST_STOP: begin
        if (i_tick) begin
          if ({stop_hi, s} == STOP_LAST) begin
            state_nxt   = ST_IDLE;
            s_nxt       = 4'd0;
            stop_hi_nxt = '0;
            if (rx) begin
              data_nxt = shreg;
              done_nxt = 1'b1;
            end else begin
              err_nxt  = 1'b1;
            end
          end else if (s == S_LAST) begin
            s_nxt       = 4'd0;
            stop_hi_nxt = stop_hi + HW'(1);
          end else begin
            s_nxt = s + 4'd1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        s_nxt     = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_IDLE;
      s       <= 4'd0;
      stop_hi <= '0;
      n       <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      stop_hi <= stop_hi_nxt;
      n       <= n_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Outputs are registered; o_data is only ever loaded from a completed,
  // correctly framed shift register, never from a frame in progress.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_data      <= data_nxt;
      o_rx_done   <= done_nxt;
      o_frame_err <= err_nxt;
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame, sent LSB first.
REQ-002 The module SHALL have parameter STOP_TICKS, default 16, meaning the stop-bit length in oversampling ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 The module SHALL have port i_clock, input, 1 bit: the single system clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port i_tick, input, 1 bit: a one-clock-wide strobe at 16x the baud rate from the baud-rate generator.
REQ-006 The module SHALL have port i_rx, input, 1 bit: the asynchronous serial line, which idles high.
REQ-007 The module SHALL have port o_data, output, DATA_BITS bits: the last received word.
REQ-008 The module SHALL have port o_rx_done, output, 1 bit: a one-clock pulse when a frame with a valid stop bit completes.
REQ-009 The module SHALL have port o_frame_err, output, 1 bit: a one-clock pulse when the sampled stop bit is low.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer before any use; "rx" below means the synchronizer output, so a line edge reaches the FSM 2 clocks late.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP, with a 4-bit tick counter s and a bit counter n of width clog2(DATA_BITS).
REQ-012 In IDLE, rx==0 SHALL move the FSM to START with s=0 on the next clock, without waiting for i_tick.
REQ-013 In START, each clock with i_tick=1 SHALL advance s, and the FSM SHALL otherwise hold.
- At the tick where s==7 (mid start bit): if rx==0, go to DATA with s=0 and n=0.
- At the same tick, if rx==1 (false start or glitch), return to IDLE with no output pulse.
REQ-014 In DATA, at the tick where s==15, the FSM SHALL shift rx into the MSB of the shift register (right shift, LSB first) and set s=0.
- If n==DATA_BITS-1 at that tick, go to STOP.
- Otherwise, increment n.
REQ-015 In STOP, at the tick where s==STOP_TICKS-1, the FSM SHALL return to IDLE.
- If rx==1: load o_data from the shift register and pulse o_rx_done.
- If rx==0: pulse o_frame_err and leave o_data unchanged.
REQ-016 o_rx_done and o_frame_err SHALL be registered, high for exactly one i_clock cycle (the cycle after the terminating tick), and never high together.
REQ-017 o_data SHALL stay stable between o_rx_done pulses and SHALL NOT expose partial shift-register contents.
REQ-018 Counters SHALL wrap only through the explicit compare-and-reset rules above; s SHALL be 4 bits wide, with STOP_TICKS-1 handled by a separate compare if it exceeds 15.
REQ-019 From IDLE, a new frame SHALL be accepted on the clock after the FSM returns to IDLE, so back-to-back frames with a single stop bit are received without loss.
REQ-020 i_tick held continuously high SHALL be legal, with one count per clock.
REQ-021 Changes on i_rx while the FSM is outside IDLE and not at a sample point SHALL have no effect.

Reset
REQ-022 While i_reset=0, asynchronously: state=IDLE, s=0, n=0, shift register=0, o_data=0, o_rx_done=0, o_frame_err=0, and both synchronizer flops=1.
REQ-023 Reset deasserted mid-frame SHALL leave the FSM in IDLE, and it SHALL re-synchronize on the next falling edge of rx.
REQ-024 Reset deassertion while i_rx=0 SHALL start a frame only after rx reads 0 through the synchronizer, treating it as a start bit; the mid-bit check rejects it if the line is not really low.

Verification
REQ-025 Drive i_tick every 4th clock and send 0xA5 (8N1) -> exactly one o_rx_done pulse, o_data=0xA5, o_frame_err=0.
REQ-026 Send 0x00 then 0xFF back-to-back with 1 stop bit -> two o_rx_done pulses, o_data=0x00 then 0xFF, no frame lost.
REQ-027 Pulse i_rx low for 4 ticks, then high -> FSM back in IDLE after the s==7 check; no o_rx_done or o_frame_err pulse; o_data unchanged.
REQ-028 Send 0x3C with the stop bit forced low -> one o_frame_err pulse, no o_rx_done, o_data keeps its previous value.
REQ-029 Assert i_reset=0 during data bit 3 of 0x5A, release it, then send 0xC3 -> outputs 0 during reset, no pulse from the aborted frame, then o_data=0xC3 with one o_rx_done.
REQ-030 Set STOP_TICKS=32 and send 0x81 with 2 stop bits -> o_rx_done fires 32 ticks after the last data sample, o_data=0x81.
